spi_txn_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one byte-wide SPI master between `N_REQ` requesters, e.g. the AHB connector, a flash loader and a sensor poller. It grants the master to one requester at a time and drives that requester's chip select. It performs the SPI master's `ready_send`/`busy` handshake for every byte and returns the received byte. Multi-byte bursts hold the lock until the requester flags the last byte. A timeout guards against a stalled master or an abandoned burst.

---
 rtl/spi_txn_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin owner of one shared byte-wide SPI master.
// Sequences CS setup, ready_send/busy handshake, burst lock and timeout.
module spi_txn_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [N_REQ-1:0]   i_req_last,
   input  logic [8*N_REQ-1:0] i_req_data,
   output logic [N_REQ-1:0]   o_gnt,
   output logic [N_REQ-1:0]   o_ack,
   output logic [7:0]         o_rx_data,
   output logic               o_err,
   output logic [N_REQ-1:0]   o_spi_cs_n,
   output logic [7:0]         o_spi_data_in,
   output logic               o_spi_ready_send,
   input  logic               i_spi_busy,
   input  logic [7:0]         i_spi_data_out
);

   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [OW-1:0] LAST_RST = OW'(N_REQ - 1);
   localparam logic [TW-1:0] T_END    = TW'(TIMEOUT - 1);
   localparam logic [N_REQ-1:0] ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_NEXT,
      S_RELEASE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [OW-1:0]    r_owner;
   logic [OW-1:0]    w_owner_nxt;
   logic [OW-1:0]    r_last_owner;
   logic [OW-1:0]    w_last_owner_nxt;
   logic             r_last_flag;
   logic             w_last_flag_nxt;
   logic [TW-1:0]    r_timer;
   logic [TW-1:0]    w_timer_nxt;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] w_gnt_nxt;
   logic [N_REQ-1:0] r_ack;
   logic [N_REQ-1:0] w_ack_nxt;
   logic [N_REQ-1:0] r_cs_n;
   logic [N_REQ-1:0] w_cs_n_nxt;
   logic [7:0]       r_rx_data;
   logic [7:0]       w_rx_nxt;
   logic [7:0]       r_data_in;
   logic [7:0]       w_data_in_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             r_ready;
   logic             w_ready_nxt;
   logic             w_load;

   logic [OW-1:0]    w_win;
   logic             w_win_vld;
   logic [N_REQ-1:0] w_win_1h;
   logic [N_REQ-1:0] w_own_1h;
   logic [7:0]       w_own_data;
   logic             w_own_last;
   logic             w_own_req;

   assign w_win_1h   = ONE << w_win;
   assign w_own_1h   = ONE << r_owner;
   assign w_own_data = i_req_data[8*r_owner +: 8];
   assign w_own_last = i_req_last[r_owner];
   assign w_own_req  = i_req[r_owner];

   // Round-robin pick: first requester above the previous owner, wrapping.
   always_comb begin
      w_win     = r_last_owner;
      w_win_vld = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!w_win_vld && i_req[(int'(r_last_owner) + k) % N_REQ]) begin
            w_win_vld = 1'b1;
            w_win     = OW'((int'(r_last_owner) + k) % N_REQ);
         end
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_last_owner_nxt = r_last_owner;
      w_last_flag_nxt  = r_last_flag;
      w_timer_nxt      = r_timer;
      w_gnt_nxt        = r_gnt;
      w_ack_nxt        = '0;
      w_cs_n_nxt       = r_cs_n;
      w_rx_nxt         = r_rx_data;
      w_data_in_nxt    = r_data_in;
      w_err_nxt        = 1'b0;
      w_ready_nxt      = r_ready;
      w_load           = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_win_vld && !i_spi_busy) begin
               w_owner_nxt = w_win;
               w_gnt_nxt   = w_win_1h;
               w_cs_n_nxt  = ~w_win_1h;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            w_load = 1'b1;
         end
         S_WAIT_BUSY: begin
            if (i_spi_busy) begin
               w_ready_nxt = 1'b0;
               w_state_nxt = S_WAIT_DONE;
            end else if (r_timer == T_END) begin
               w_ready_nxt = 1'b0;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_RELEASE;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!i_spi_busy) begin
               w_rx_nxt  = i_spi_data_out;
               w_ack_nxt = w_own_1h;
               if (r_last_flag) begin
                  w_state_nxt = S_RELEASE;
               end else begin
                  w_timer_nxt = '0;
                  w_state_nxt = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            // The requester is still reacting to ack, so its req is stale.
            if (!(|r_ack) && w_own_req) begin
               w_load = 1'b1;
            end else if (r_timer == T_END) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_RELEASE;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_RELEASE: begin
            w_gnt_nxt        = '0;
            w_cs_n_nxt       = '1;
            w_last_owner_nxt = r_owner;
            w_state_nxt      = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (w_load) begin
         w_data_in_nxt   = w_own_data;
         w_last_flag_nxt = w_own_last;
         w_ready_nxt     = 1'b1;
         w_timer_nxt     = '0;
         w_state_nxt     = S_WAIT_BUSY;
      end
   end

   // State register and sequencing bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_last_owner <= LAST_RST;
         r_last_flag  <= 1'b0;
         r_timer      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_last_flag  <= w_last_flag_nxt;
         r_timer      <= w_timer_nxt;
      end
   end

   // Registered outputs toward requesters and the SPI master.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt     <= '0;
         r_ack     <= '0;
         r_cs_n    <= '1;
         r_rx_data <= '0;
         r_data_in <= '0;
         r_err     <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         r_gnt     <= w_gnt_nxt;
         r_ack     <= w_ack_nxt;
         r_cs_n    <= w_cs_n_nxt;
         r_rx_data <= w_rx_nxt;
         r_data_in <= w_data_in_nxt;
         r_err     <= w_err_nxt;
         r_ready   <= w_ready_nxt;
      end
   end

   assign o_gnt            = r_gnt;
   assign o_ack            = r_ack;
   assign o_rx_data        = r_rx_data;
   assign o_err            = r_err;
   assign o_spi_cs_n       = r_cs_n;
   assign o_spi_data_in    = r_data_in;
   assign o_spi_ready_send = r_ready;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed scenarios with an SPI master model,
// requester queues and a transaction-level reference model.
module tb_spi_txn_arbiter;

   localparam int N  = 4;
   localparam int TO = 12;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   req_last = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic [7:0]     rx_data;
   logic           err;
   logic [N-1:0]   cs_n;
   logic [7:0]     data_in;
   logic           ready;
   logic           busy = 1'b0;
   logic [7:0]     data_out = 8'h00;
   logic           stall = 1'b0;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   logic [8:0] rq_mem [N][64];
   int         rq_head [N];
   int         rq_tail [N];

   int glog [64];
   int alog [64];
   int gcnt = 0;
   int acnt = 0;
   int errcnt = 0;

   logic         m_rst_prev = 1'b0;
   logic [N-1:0] m_req_prev = '0;
   logic         m_busy_prev = 1'b0;
   logic [N-1:0] m_gnt_prev = '0;
   logic         m_ready_prev = 1'b0;
   int           m_last = N - 1;
   int           m_gnt_cyc = 0;
   int           m_ack_cyc = 0;
   int           m_ref = 0;
   int           m_rdy_cyc = 0;
   int           m_req_rise_cyc = 0;
   logic         m_first = 1'b0;
   logic [7:0]   m_sent = 8'h00;
   logic [N-1:0] m_cs_grant = '1;
   logic [7:0]   m_b;
   int           exp_rr [5] = '{0, 1, 2, 3, 0};

   spi_txn_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_req           (req),
      .i_req_last      (req_last),
      .i_req_data      (req_data),
      .o_gnt           (gnt),
      .o_ack           (ack),
      .o_rx_data       (rx_data),
      .o_err           (err),
      .o_spi_cs_n      (cs_n),
      .o_spi_data_in   (data_in),
      .o_spi_ready_send(ready),
      .i_spi_busy      (busy),
      .i_spi_data_out  (data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   function automatic int idx_of(input logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return 0;
   endfunction

   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (last + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic pending();
      for (int i = 0; i < N; i++) if (rq_head[i] != rq_tail[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push(input int i, input logic [7:0] b, input logic l);
      rq_mem[i][rq_tail[i]] = {l, b};
      rq_tail[i]++;
   endtask

   // SPI master: echoes tx ^ 0x99 after 8 busy cycles unless stalled.
   initial begin
      forever begin
         @(negedge clk);
         if (ready && !stall && !busy) begin
            m_b = data_in ^ 8'h99;
            @(posedge clk);
            #1 busy = 1'b1;
            repeat (8) @(posedge clk);
            #1 busy = 1'b0;
            data_out = m_b;
         end
      end
   end

   // Requesters: present queue heads, advance on ack or err.
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < N; i++) begin
         if (rst) rq_head[i] = rq_tail[i];
         else if (rq_head[i] != rq_tail[i] && (ack[i] || (err && gnt[i])))
            rq_head[i]++;
         if (rq_head[i] != rq_tail[i]) begin
            req[i]            = 1'b1;
            req_last[i]       = rq_mem[i][rq_head[i]][8];
            req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
         end else begin
            req[i]      = 1'b0;
            req_last[i] = 1'b0;
         end
      end
   end

   // Reference model and per-cycle comparison.
   always @(negedge clk) begin
      if (m_rst_prev) begin
         chk("rst_gnt", gnt, 0);
         chk("rst_ack", ack, 0);
         chk("rst_rx", rx_data, 0);
         chk("rst_err", err, 0);
         chk("rst_cs", cs_n, 4'hF);
         chk("rst_din", data_in, 0);
         chk("rst_ready", ready, 0);
         m_last  = N - 1;
         m_first = 1'b0;
      end else begin
         chk("gnt_onehot", $onehot0(gnt), 1);
         chk("cs_vs_gnt", cs_n ^ gnt, 4'hF);
         if (gnt != 0 && m_gnt_prev == 0) begin
            chk("grant_owner", idx_of(gnt), rr_pick(m_last, m_req_prev));
            chk("grant_busy_low", m_busy_prev, 0);
            glog[gcnt] = idx_of(gnt);
            gcnt++;
            m_gnt_cyc  = cyc;
            m_first    = 1'b1;
            m_cs_grant = cs_n;
         end
         if (gnt == 0 && m_gnt_prev != 0) m_last = idx_of(m_gnt_prev);
         if (ready && !m_ready_prev) begin
            m_sent = req_data[8*idx_of(gnt) +: 8];
            chk("tx_byte", data_in, m_sent);
            if (m_first) chk("setup_lat", cyc - m_gnt_cyc, 1);
            else chk("burst_gap", (cyc - m_ack_cyc) >= 2, 1);
            m_first   = 1'b0;
            m_ref     = cyc;
            m_rdy_cyc = cyc;
         end
         if (ready) chk("ready_vs_busy", m_busy_prev, 0);
         if (ack != 0) begin
            chk("ack_owner", ack, gnt);
            chk("ack_busy_low", m_busy_prev, 0);
            chk("rx_byte", rx_data, m_sent ^ 8'h99);
            alog[acnt] = idx_of(ack);
            acnt++;
            m_ack_cyc = cyc;
            m_ref     = cyc;
         end
         if (err) begin
            chk("err_delay", cyc - m_ref, TO);
            chk("err_no_ack", ack, 0);
            errcnt++;
         end
      end
      if (req != 0 && m_req_prev == 0) m_req_rise_cyc = cyc;
      m_rst_prev   = rst;
      m_req_prev   = req;
      m_busy_prev  = busy;
      m_gnt_prev   = gnt;
      m_ready_prev = ready;
   end

   task automatic wait_done(input int budget);
      int t = 0;
      repeat (2) @(negedge clk);
      while ((pending() || gnt != 0 || busy) && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("wait_budget", t < budget, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int g0;
      int a0;
      int e0;
      int t;
      for (int i = 0; i < N; i++) begin
         rq_head[i] = 0;
         rq_tail[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // Round-robin from reset: 0,1,2,3 then 0 again.
      #1 g0 = gcnt;
      a0 = acnt;
      push(0, 8'h10, 1'b1);
      push(1, 8'h21, 1'b1);
      push(2, 8'h32, 1'b1);
      push(3, 8'h43, 1'b1);
      push(0, 8'h54, 1'b1);
      wait_done(400);
      for (int k = 0; k < 5; k++) chk("rr_order", glog[g0 + k], exp_rr[k]);
      chk("rr_acks", acnt - a0, 5);

      // Single byte 0xA5 -> 0x3C.
      @(posedge clk);
      #1 a0 = acnt;
      push(0, 8'hA5, 1'b1);
      wait_done(200);
      chk("t1_cs", m_cs_grant, 4'b1110);
      chk("t1_din", data_in, 8'hA5);
      chk("t1_ready_lat", m_rdy_cyc - m_req_rise_cyc, 2);
      chk("t1_rx", rx_data, 8'h3C);
      chk("t1_ack_cnt", acnt - a0, 1);
      chk("t1_ack_owner", alog[a0], 0);
      chk("t1_cs_rel", cs_n, 4'hF);

      // Burst lock for requester 2 while requester 0 waits.
      @(posedge clk);
      #1 g0 = gcnt;
      a0 = acnt;
      push(2, 8'h9F, 1'b0);
      push(2, 8'h00, 1'b0);
      push(2, 8'h00, 1'b1);
      push(0, 8'h77, 1'b1);
      wait_done(400);
      chk("burst_grants", gcnt - g0, 2);
      chk("burst_g0", glog[g0], 2);
      chk("burst_g1", glog[g0 + 1], 0);
      chk("burst_acks", acnt - a0, 4);
      for (int k = 0; k < 3; k++) chk("burst_ack2", alog[a0 + k], 2);
      chk("burst_ack0", alog[a0 + 3], 0);

      // Master stall: requester 1 times out, requester 3 served next.
      @(posedge clk);
      #1 g0 = gcnt;
      a0 = acnt;
      e0 = errcnt;
      stall = 1'b1;
      push(1, 8'h5A, 1'b1);
      push(3, 8'h6B, 1'b1);
      t = 0;
      while (errcnt == e0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("stall_err_seen", t < 200, 1);
      stall = 1'b0;
      wait_done(200);
      chk("stall_errs", errcnt - e0, 1);
      chk("stall_acks", acnt - a0, 1);
      chk("stall_ack3", alog[a0], 3);
      chk("stall_g0", glog[g0], 1);
      chk("stall_g1", glog[g0 + 1], 3);

      // Abandoned burst: owner drops req after a non-last byte.
      @(posedge clk);
      #1 g0 = gcnt;
      a0 = acnt;
      e0 = errcnt;
      push(1, 8'hC3, 1'b0);
      wait_done(200);
      chk("aband_grants", gcnt - g0, 1);
      chk("aband_g0", glog[g0], 1);
      chk("aband_acks", acnt - a0, 1);
      chk("aband_errs", errcnt - e0, 1);
      chk("aband_cs", cs_n, 4'hF);

      // Reset while the master is shifting for requester 2.
      @(posedge clk);
      #1 push(2, 8'h11, 1'b1);
      push(3, 8'h22, 1'b1);
      t = 0;
      while (!(busy && !ready && gnt == 4'b0100) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("rst_mid_reached", t < 200, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 g0 = gcnt;
      push(3, 8'h33, 1'b1);
      push(0, 8'h44, 1'b1);
      @(negedge clk);
      chk("rst_wait_busy", gnt, 0);
      wait_done(300);
      chk("rst_grants", gcnt - g0, 2);
      chk("rst_first0", glog[g0], 0);
      chk("rst_then3", glog[g0 + 1], 3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
